// File: rtl/alu_seq_if.sv
// Operand / control / status bundle between the CPU controller and alu_seq.
// The controller drives operands, opcode, start and the bus enable. The ALU
// returns its handshake and registered flags. The tri-state data bus itself
// is a separate plain net because it is resolved with other bus drivers.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_out;
  logic             alu_busy;
  logic             alu_done;
  logic             alu_cy;
  logic             alu_z;
  logic             alu_n;

  // Controller side
  modport master (
    output alu_a, alu_b, alu_op, alu_start, alu_out,
    input  alu_busy, alu_done, alu_cy, alu_z, alu_n
  );

  // ALU side
  modport slave (
    input  alu_a, alu_b, alu_op, alu_start, alu_out,
    output alu_busy, alu_done, alu_cy, alu_z, alu_n
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the 8-bit CPU datapath.
// Operations: ADD/SUB/ADC/SBC/AND/OR/XOR complete in a single cycle. MUL is an
// iterative unsigned shift-add multiplier taking WIDTH steps.
// Result and flags are registered. The result drives the shared bus through
// a tri-state enable.
// Build option: define ALU_MUL_EN to build the multiplier. Without it, op 111
// completes in one cycle with a zero result, and alu_busy is tied low.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_if.slave         bus_if,
  output wire [WIDTH-1:0]  alu_bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ADC = 3'b010,
    OP_SBC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  // Architectural state visible outside the block
  logic [WIDTH-1:0] result_q, result_d;
  logic             cy_q, cy_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             done_q, done_d;

  op_e              op_in;
  logic             accept;
  logic             sc_take;

  // Single-cycle datapath, computed one bit wider so bit WIDTH is carry/borrow
  logic [WIDTH:0]   opa_ext;
  logic [WIDTH:0]   opb_ext;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   sc_wide;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cy;

  assign op_in   = op_e'(bus_if.alu_op);
  assign opa_ext = {1'b0, bus_if.alu_a};
  assign opb_ext = {1'b0, bus_if.alu_b};
  assign cin_ext = {{WIDTH{1'b0}}, cy_q};

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   step_sum;
  logic                 is_mul;

  // Starts issued while a multiply is running are dropped.
  assign accept   = bus_if.alu_start && !busy_q;
  assign is_mul   = (op_in == OP_MUL);
  assign sc_take  = accept && !is_mul;
  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  assign step_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`else
  assign accept   = bus_if.alu_start;
  assign sc_take  = accept;
`endif

  // Single-cycle result and carry/borrow for the currently presented opcode
  always_comb begin
    case (op_in)
      OP_ADD:  sc_wide = opa_ext + opb_ext;
      OP_SUB:  sc_wide = opa_ext - opb_ext;
      OP_ADC:  sc_wide = opa_ext + opb_ext + cin_ext;
      OP_SBC:  sc_wide = opa_ext - opb_ext - cin_ext;
      OP_AND:  sc_wide = {1'b0, bus_if.alu_a & bus_if.alu_b};
      OP_OR:   sc_wide = {1'b0, bus_if.alu_a | bus_if.alu_b};
      OP_XOR:  sc_wide = {1'b0, bus_if.alu_a ^ bus_if.alu_b};
      // MUL never takes this path when the multiplier is built; without it
      // the zero result and cleared carry are exactly what op 111 returns.
      default: sc_wide = '0;
    endcase
    sc_res = sc_wide[WIDTH-1:0];
    sc_cy  = sc_wide[WIDTH];
  end

  // Next-state: accept new ops, step the multiplier, update result and flags
  always_comb begin
    result_d = result_q;
    cy_d     = cy_q;
    z_d      = z_q;
    n_d      = n_q;
    done_d   = 1'b0;
`ifdef ALU_MUL_EN
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      // Last step: publish the low half, carry flags any overflow into the high half.
      if (cnt_q == CW'(1)) begin
        result_d = step_sum[WIDTH-1:0];
        cy_d     = |step_sum[2*WIDTH-1:WIDTH];
        z_d      = (step_sum[WIDTH-1:0] == '0);
        n_d      = step_sum[WIDTH-1];
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
    end else if (accept && is_mul) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, bus_if.alu_a};
      mplier_d = bus_if.alu_b;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end
`endif
    if (sc_take) begin
      result_d = sc_res;
      cy_d     = sc_cy;
      z_d      = (sc_res == '0);
      n_d      = sc_res[WIDTH-1];
      done_d   = 1'b1;
    end
  end

  // State registers; reset aborts any running multiply without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cy_q     <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      result_q <= result_d;
      cy_q     <= cy_d;
      z_q      <= z_d;
      n_q      <= n_d;
      done_q   <= done_d;
`ifdef ALU_MUL_EN
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

`ifdef ALU_MUL_EN
  assign bus_if.alu_busy = busy_q;
`else
  assign bus_if.alu_busy = 1'b0;
`endif
  assign bus_if.alu_done = done_q;
  assign bus_if.alu_cy   = cy_q;
  assign bus_if.alu_z    = z_q;
  assign bus_if.alu_n    = n_q;

  // Bus drivers: the result register is shown whenever enabled, busy or not.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bus
    assign alu_bus[gi] = bus_if.alu_out ? result_q[gi] : 1'bz;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed scenarios plus randomized ops, checked
// against an arithmetic reference model. Follows ALU_MUL_EN like the RTL.
module tb_alu_seq;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [W-1:0] bus_w;

  alu_seq_if #(.WIDTH(W)) bif ();

  alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus_if  (bif),
    .alu_bus (bus_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int m_r = 0;
  int m_cy = 0;
  int m_z = 0;
  int m_n = 0;

  string op_name [8] = '{"ADD", "SUB", "ADC", "SBC", "AND", "OR", "XOR", "MUL"};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference behaviour of one completed op, from plain integer arithmetic.
  function automatic void model_op(input int op, input int a, input int b);
    int t;
    case (op)
      0: begin t = a + b;        m_r = t & MASK; m_cy = (t > MASK) ? 1 : 0; end
      1: begin t = a - b;        m_r = t & MASK; m_cy = (a < b) ? 1 : 0;    end
      2: begin t = a + b + m_cy; m_r = t & MASK; m_cy = (t > MASK) ? 1 : 0; end
      3: begin t = a - b - m_cy; m_r = t & MASK; m_cy = (t < 0) ? 1 : 0;    end
      4: begin m_r = a & b; m_cy = 0; end
      5: begin m_r = a | b; m_cy = 0; end
      6: begin m_r = a ^ b; m_cy = 0; end
      default: begin
`ifdef ALU_MUL_EN
        t = a * b;
        m_r = t & MASK;
        m_cy = ((t >> W) != 0) ? 1 : 0;
`else
        m_r = 0;
        m_cy = 0;
`endif
      end
    endcase
    m_z = (m_r == 0) ? 1 : 0;
    m_n = (m_r >> (W - 1)) & 1;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_r"}, int'(bus_w), m_r);
    check_eq({tag, "_cy"}, int'(bif.alu_cy), m_cy);
    check_eq({tag, "_z"}, int'(bif.alu_z), m_z);
    check_eq({tag, "_n"}, int'(bif.alu_n), m_n);
  endtask

  // Issue one op with a one-cycle start pulse and follow it to completion.
  // poke=1 fires an ADD start in the middle of a multiply, which must be ignored.
  task automatic run_op(input int op, input int a, input int b, input bit poke);
    bit is_multi;
    int busy_cycles;
    int old_r;
    string tg;
    tg = op_name[op];
    old_r = m_r;
    @(negedge clk);
    bif.alu_op = 3'(op);
    bif.alu_a = W'(a);
    bif.alu_b = W'(b);
    bif.alu_start = 1'b1;
    @(negedge clk);
    bif.alu_start = 1'b0;
    model_op(op, a, b);
`ifdef ALU_MUL_EN
    is_multi = (op == 7);
`else
    is_multi = 1'b0;
`endif
    if (is_multi) begin
      busy_cycles = 0;
      while (bif.alu_busy && busy_cycles < 4 * W) begin
        check_eq("mul_done_while_busy", int'(bif.alu_done), 0);
        check_eq("mul_bus_holds_prev", int'(bus_w), old_r);
        if (poke && busy_cycles == 2) begin
          bif.alu_op = 3'd0;
          bif.alu_a = W'(1);
          bif.alu_b = W'(1);
          bif.alu_start = 1'b1;
        end else begin
          bif.alu_start = 1'b0;
        end
        @(negedge clk);
        busy_cycles++;
      end
      bif.alu_start = 1'b0;
      check_eq("mul_busy_cycles", busy_cycles, W);
    end else begin
      check_eq({tg, "_busy_low"}, int'(bif.alu_busy), 0);
    end
    check_eq({tg, "_done"}, int'(bif.alu_done), 1);
    check_state(tg);
    $display("op=%s a=%0d b=%0d -> r=%0d cy=%0d z=%0d n=%0d", tg, a, b, int'(bus_w),
             int'(bif.alu_cy), int'(bif.alu_z), int'(bif.alu_n));
    @(negedge clk);
    check_eq({tg, "_done_once"}, int'(bif.alu_done), 0);
  endtask

  // Hold start high for n cycles with fresh single-cycle ops each cycle.
  task automatic run_b2b(input int n);
    int op;
    int a;
    int b;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(0, 6));
      a = int'($urandom_range(0, MASK));
      b = int'($urandom_range(0, MASK));
      bif.alu_op = 3'(op);
      bif.alu_a = W'(a);
      bif.alu_b = W'(b);
      bif.alu_start = 1'b1;
      @(negedge clk);
      model_op(op, a, b);
      check_eq("b2b_done", int'(bif.alu_done), 1);
      check_state("b2b");
      $display("b2b op=%s a=%0d b=%0d -> r=%0d cy=%0d", op_name[op], a, b, int'(bus_w), int'(bif.alu_cy));
    end
    bif.alu_start = 1'b0;
    @(negedge clk);
    check_eq("b2b_done_drop", int'(bif.alu_done), 0);
  endtask

  initial begin
    bif.alu_a = '0;
    bif.alu_b = '0;
    bif.alu_op = 3'd0;
    bif.alu_start = 1'b0;
    bif.alu_out = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    check_eq("rst_r", int'(bus_w), 0);
    check_eq("rst_cy", int'(bif.alu_cy), 0);
    check_eq("rst_z", int'(bif.alu_z), 0);
    check_eq("rst_n_flag", int'(bif.alu_n), 0);
    check_eq("rst_busy", int'(bif.alu_busy), 0);
    check_eq("rst_done", int'(bif.alu_done), 0);
    rst_n = 1'b1;

    // Basic add, then release the bus
    run_op(0, 10, 10, 1'b0);
    bif.alu_out = 1'b0;
    #1;
    check_eq("bus_released", (bus_w !== W'(20)) ? 1 : 0, 1);
    bif.alu_out = 1'b1;
    #1;
    check_eq("bus_redriven", int'(bus_w), 20);

    // Subtract, carry chain and logic-op carry clear
    run_op(1, 10, 10, 1'b0);
    run_op(1, 100, 200, 1'b0);
    run_op(0, 200, 100, 1'b0);
    run_op(2, 1, 1, 1'b0);
    run_op(3, 5, 5, 1'b0);
    run_op(0, 200, 100, 1'b0);
    run_op(6, 8'hAA, 8'hAA, 1'b0);
    run_op(3, 0, 255, 1'b0);
    run_op(2, 255, 255, 1'b0);

    // Multiply, including an ignored mid-op start
    run_op(7, 12, 11, 1'b0);
    run_op(7, 200, 100, 1'b1);
    run_op(7, 255, 255, 1'b0);
    run_op(7, 0, 77, 1'b0);

    run_b2b(6);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    bif.alu_op = 3'd7;
    bif.alu_a = W'(12);
    bif.alu_b = W'(11);
    bif.alu_start = 1'b1;
    @(negedge clk);
    bif.alu_start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_r = 0;
    m_cy = 0;
    m_z = 0;
    m_n = 0;
    check_eq("midrst_busy", int'(bif.alu_busy), 0);
    check_eq("midrst_done", int'(bif.alu_done), 0);
    check_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check_eq("midrst_no_done", int'(bif.alu_done), 0);
    end
    check_state("postrst");

    // Machine still works after reset
    run_op(0, 3, 4, 1'b0);
    run_op(7, 13, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
